// File: rtl/spi_sensor_pkg.sv
// Shared state encoding, default timing and sizing helpers for the SPI sensor receiver.
// Imported by spi_sclk_gen and spi_sensor_rx.
package spi_sensor_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETUP,
      ST_SHIFT,
      ST_QUIET
   } state_t;

   localparam int DEF_FRAME_BITS   = 16;
   localparam int DEF_DATA_W       = 8;
   localparam int DEF_DATA_LSB     = 4;
   localparam int DEF_CLK_DIV      = 2;
   localparam int DEF_CS_SETUP_CYC = 2;
   localparam int DEF_QUIET_CYC    = 4;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // Bits needed to hold the values 0..max_val (at least one bit).
   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK generator: half-period counter and sclk flop, with rise / end-of-high-half strobes
// that tell the frame FSM when a bit is captured and when the last high half has elapsed.
module spi_sclk_gen
   import spi_sensor_pkg::*;
#(
   parameter int CLK_DIV = DEF_CLK_DIV
)(
   input  logic clk,
   input  logic rst,
   input  logic launch,
   input  logic run,
   input  logic hold,
   output logic sclk,
   output logic rise,
   output logic high_end
);

   localparam int CNT_W = cnt_width(CLK_DIV);

   logic [CNT_W-1:0] half_cnt;
   logic             tick;

   assign tick     = run && (half_cnt == CNT_W'(CLK_DIV - 1));
   assign rise     = tick && !sclk;
   assign high_end = tick && sclk;

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk) begin
      if (rst) begin
         sclk     <= 1'b1;
         half_cnt <= '0;
      end else if (launch) begin
         sclk     <= 1'b0;
         half_cnt <= '0;
      end else if (run) begin
         if (tick) begin
            half_cnt <= '0;
            // After the final rise the line stays high; the FSM leaves SHIFT here.
            if (!(sclk && hold))
               sclk <= ~sclk;
         end else begin
            half_cnt <= half_cnt + CNT_W'(1);
         end
      end else begin
         sclk     <= 1'b1;
         half_cnt <= '0;
      end
   end

endmodule

// File: rtl/spi_sensor_rx.sv
// SPI master receiver for fixed-length sensor frames: CS/SCLK sequencing, MSB-first capture,
// field extraction and a valid/ready result port with sticky overrun.
module spi_sensor_rx
   import spi_sensor_pkg::*;
#(
   parameter int FRAME_BITS   = DEF_FRAME_BITS,
   parameter int DATA_W       = DEF_DATA_W,
   parameter int DATA_LSB     = DEF_DATA_LSB,
   parameter int CLK_DIV      = DEF_CLK_DIV,
   parameter int CS_SETUP_CYC = DEF_CS_SETUP_CYC,
   parameter int QUIET_CYC    = DEF_QUIET_CYC
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  continuous,
   output logic                  busy,
   output logic                  ss_n,
   output logic                  sclk,
   input  logic                  miso,
   output logic [DATA_W-1:0]     data_out,
   output logic [FRAME_BITS-1:0] frame_raw,
   output logic                  data_valid,
   input  logic                  data_ready,
   output logic                  overrun
);

   localparam int TMR_W = cnt_width(max2(CS_SETUP_CYC, QUIET_CYC));
   localparam int BIT_W = cnt_width(FRAME_BITS);

   if ((DATA_LSB < 0) || (DATA_LSB + DATA_W > FRAME_BITS) || (FRAME_BITS < 2) ||
       (CLK_DIV < 1) || (CS_SETUP_CYC < 1) || (QUIET_CYC < 1)) begin : g_param_check
      $error("spi_sensor_rx: illegal parameter combination");
   end

   state_t                state, state_next;
   logic [TMR_W-1:0]      tmr, tmr_next;
   logic [BIT_W-1:0]      bit_cnt;
   logic [FRAME_BITS-1:0] sr;
   logic                  launch, complete, run, rise, high_end, frame_done;

   assign run        = (state == ST_SHIFT);
   assign frame_done = (bit_cnt == BIT_W'(FRAME_BITS));

   spi_sclk_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_sclk_gen (
      .clk      (clk),
      .rst      (rst),
      .launch   (launch),
      .run      (run),
      .hold     (frame_done),
      .sclk     (sclk),
      .rise     (rise),
      .high_end (high_end)
   );

   // NOTE: every output of this block gets a default before the case, so no
   // path leaves a signal unassigned and no latch is inferred.
   always_comb begin
      state_next = state;
      tmr_next   = '0;
      launch     = 1'b0;
      complete   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start)
               state_next = ST_SETUP;
         end
         ST_SETUP: begin
            if (tmr == TMR_W'(CS_SETUP_CYC - 1)) begin
               state_next = ST_SHIFT;
               launch     = 1'b1;
            end else begin
               tmr_next = tmr + TMR_W'(1);
            end
         end
         ST_SHIFT: begin
            if (high_end && frame_done) begin
               state_next = ST_QUIET;
               complete   = 1'b1;
            end
         end
         ST_QUIET: begin
            if (tmr == TMR_W'(QUIET_CYC - 1))
               state_next = continuous ? ST_SETUP : ST_IDLE;
            else
               tmr_next = tmr + TMR_W'(1);
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // ss_n and busy are registered from the next state so the pins never glitch.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         tmr   <= '0;
         busy  <= 1'b0;
         ss_n  <= 1'b1;
      end else begin
         state <= state_next;
         tmr   <= tmr_next;
         busy  <= (state_next != ST_IDLE);
         ss_n  <= !((state_next == ST_SETUP) || (state_next == ST_SHIFT));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bit_cnt <= '0;
         sr      <= '0;
      end else if (launch) begin
         bit_cnt <= '0;
      end else if (rise) begin
         sr      <= {sr[FRAME_BITS-2:0], miso};
         bit_cnt <= bit_cnt + BIT_W'(1);
      end
   end

   // A completion landing on an acceptance cycle is a clean handoff, not an overwrite.
   always_ff @(posedge clk) begin
      if (rst) begin
         data_out   <= '0;
         frame_raw  <= '0;
         data_valid <= 1'b0;
         overrun    <= 1'b0;
      end else if (complete) begin
         frame_raw  <= sr;
         data_out   <= sr[DATA_LSB +: DATA_W];
         data_valid <= 1'b1;
         if (data_valid)
            overrun <= !data_ready;
      end else if (data_valid && data_ready) begin
         data_valid <= 1'b0;
         overrun    <= 1'b0;
      end
   end

endmodule

// File: tb/tb_spi_sensor_rx.sv
// Directed bench for spi_sensor_rx: default instance plus a CLK_DIV=1 / 12-bit-frame instance,
// each fed by a behavioural sensor that shifts queued words out MSB-first on sclk falls.
module tb_spi_sensor_rx;
   import spi_sensor_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst = 1'b1;

   logic        start_a = 1'b0, continuous_a = 1'b0, data_ready_a = 1'b0, miso_a = 1'b0;
   logic        busy_a, ss_n_a, sclk_a, data_valid_a, overrun_a;
   logic [7:0]  data_out_a;
   logic [15:0] frame_raw_a;

   logic        start_b = 1'b0, continuous_b = 1'b0, data_ready_b = 1'b1, miso_b = 1'b0;
   logic        busy_b, ss_n_b, sclk_b, data_valid_b, overrun_b;
   logic [11:0] data_out_b;
   logic [11:0] frame_raw_b;

   spi_sensor_rx u_dut_a (
      .clk        (clk),
      .rst        (rst),
      .start      (start_a),
      .continuous (continuous_a),
      .busy       (busy_a),
      .ss_n       (ss_n_a),
      .sclk       (sclk_a),
      .miso       (miso_a),
      .data_out   (data_out_a),
      .frame_raw  (frame_raw_a),
      .data_valid (data_valid_a),
      .data_ready (data_ready_a),
      .overrun    (overrun_a)
   );

   spi_sensor_rx #(
      .FRAME_BITS   (12),
      .DATA_W       (12),
      .DATA_LSB     (0),
      .CLK_DIV      (1),
      .CS_SETUP_CYC (2),
      .QUIET_CYC    (4)
   ) u_dut_b (
      .clk        (clk),
      .rst        (rst),
      .start      (start_b),
      .continuous (continuous_b),
      .busy       (busy_b),
      .ss_n       (ss_n_b),
      .sclk       (sclk_b),
      .miso       (miso_b),
      .data_out   (data_out_b),
      .frame_raw  (frame_raw_b),
      .data_valid (data_valid_b),
      .data_ready (data_ready_b),
      .overrun    (overrun_b)
   );

   // Sensor models: words to transmit, and the scoreboard of expected results.
   logic [15:0] tx_a_q[$];
   logic [15:0] exp_a_q[$];
   logic [11:0] tx_b_q[$];
   logic [11:0] exp_b_q[$];
   logic [15:0] cur_a = '0;
   logic [11:0] cur_b = '0;
   int          idx_a = -1, idx_b = -1;

   always @(negedge ss_n_a) begin
      if (tx_a_q.size() > 0) cur_a = tx_a_q.pop_front();
      else                   cur_a = '0;
      idx_a = 15;
   end
   always @(negedge sclk_a) begin
      if (ss_n_a === 1'b0 && idx_a >= 0) begin
         miso_a = cur_a[idx_a];
         idx_a--;
      end
   end

   always @(negedge ss_n_b) begin
      if (tx_b_q.size() > 0) cur_b = tx_b_q.pop_front();
      else                   cur_b = '0;
      idx_b = 11;
   end
   always @(negedge sclk_b) begin
      if (ss_n_b === 1'b0 && idx_b >= 0) begin
         miso_b = cur_b[idx_b];
         idx_b--;
      end
   end

   int  rises_a = 0, rises_b = 0;
   time last_rise_b = 0, period_b = 0;
   always @(posedge sclk_a) rises_a++;
   always @(posedge sclk_b) begin
      period_b    = $time - last_rise_b;
      last_rise_b = $time;
      rises_b++;
   end

   int   errors = 0, checks = 0;
   int   cnt, base, q, falls, pulses;
   logic prev_ss, seen_dv;
   logic [15:0] dropped;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] field_a(input logic [15:0] w);
      return w[11:4];
   endfunction

   task automatic push_a(input logic [15:0] w);
      tx_a_q.push_back(w);
      exp_a_q.push_back(w);
   endtask

   task automatic compare_a(input string tag);
      logic [15:0] e;
      e = 'x;
      if (exp_a_q.size() > 0) e = exp_a_q.pop_front();
      check({tag, "_frame_raw"}, 32'(frame_raw_a), 32'(e));
      check({tag, "_data_out"}, 32'(data_out_a), 32'(field_a(e)));
   endtask

   task automatic wait_ss_a(input logic lvl, input string tag);
      int n;
      n = 0;
      while (ss_n_a !== lvl && n < 400) begin
         @(negedge clk);
         n++;
      end
      check(tag, 32'(ss_n_a), 32'(lvl));
   endtask

   task automatic wait_idle_a(input string tag);
      int n;
      n = 0;
      while (busy_a !== 1'b0 && n < 400) begin
         @(negedge clk);
         n++;
      end
      check(tag, 32'(busy_a), 32'd0);
   endtask

   task automatic pulse_start_a();
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
   endtask

   task automatic accept_a(input string tag);
      data_ready_a = 1'b1;
      @(negedge clk);
      data_ready_a = 1'b0;
      check({tag, "_valid_cleared"}, 32'(data_valid_a), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      // Reset values
      repeat (3) @(negedge clk);
      check("rst_ss_n", 32'(ss_n_a), 32'd1);
      check("rst_sclk", 32'(sclk_a), 32'd1);
      check("rst_busy", 32'(busy_a), 32'd0);
      check("rst_data_out", 32'(data_out_a), 32'd0);
      check("rst_frame_raw", 32'(frame_raw_a), 32'd0);
      check("rst_valid", 32'(data_valid_a), 32'd0);
      check("rst_overrun", 32'(overrun_a), 32'd0);
      check("rst_b_ss_n", 32'(ss_n_b), 32'd1);
      rst = 1'b0;
      @(negedge clk);

      // Single-shot frame: CS window, rise count, result
      push_a(16'h0A5C);
      base = rises_a;
      pulse_start_a();
      check("t1_ss_low_next_cycle", 32'(ss_n_a), 32'd0);
      check("t1_busy", 32'(busy_a), 32'd1);
      cnt = 1;
      while (ss_n_a === 1'b0 && cnt < 400) begin
         @(negedge clk);
         if (ss_n_a === 1'b0) cnt++;
      end
      check("t1_ss_low_cycles", 32'(cnt), 32'd66);
      check("t1_sclk_rises", 32'(rises_a - base), 32'd16);
      check("t1_valid", 32'(data_valid_a), 32'd1);
      compare_a("t1");
      check("t1_overrun", 32'(overrun_a), 32'd0);
      accept_a("t1");

      // Two continuous frames with no acceptance -> overrun
      wait_idle_a("t2_idle_before");
      push_a(16'h0A5C);
      push_a(16'h0FF0);
      continuous_a = 1'b1;
      pulse_start_a();
      wait_ss_a(1'b1, "t2_f1_done");
      check("t2_f1_valid", 32'(data_valid_a), 32'd1);
      check("t2_f1_data", 32'(data_out_a), 32'(field_a(exp_a_q[0])));
      check("t2_f1_overrun", 32'(overrun_a), 32'd0);
      wait_ss_a(1'b0, "t2_f2_start");
      continuous_a = 1'b0;
      wait_ss_a(1'b1, "t2_f2_done");
      check("t2_overrun_set", 32'(overrun_a), 32'd1);
      dropped = exp_a_q.pop_front();
      compare_a("t2_f2");
      accept_a("t2");
      check("t2_overrun_cleared", 32'(overrun_a), 32'd0);
      repeat (10) @(negedge clk);
      check("t2_idle_after_stop", 32'(busy_a), 32'd0);

      // Continuous with consumer always ready: three back-to-back frames
      push_a(16'h1234);
      push_a(16'hBEEF);
      push_a(16'h0001);
      continuous_a = 1'b1;
      data_ready_a = 1'b1;
      pulse_start_a();
      for (int f = 0; f < 3; f++) begin
         wait_ss_a(1'b0, "t3_frame_start");
         if (f == 2) continuous_a = 1'b0;
         wait_ss_a(1'b1, "t3_frame_done");
         check("t3_valid", 32'(data_valid_a), 32'd1);
         compare_a("t3");
         @(negedge clk);
         check("t3_auto_accept", 32'(data_valid_a), 32'd0);
         if (f < 2) begin
            q = 2;
            while (ss_n_a === 1'b1 && q < 50) begin
               @(negedge clk);
               if (ss_n_a === 1'b1) q++;
            end
            check("t3_quiet_cycles", 32'(q), 32'd4);
         end
      end
      wait_idle_a("t3_idle_after");

      // start held high: one frame per IDLE entry, nothing queued while busy
      push_a(16'h0F0F);
      push_a(16'h7777);
      falls   = 0;
      pulses  = 0;
      prev_ss = ss_n_a;
      start_a = 1'b1;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (i == 80) start_a = 1'b0;
         if (prev_ss === 1'b1 && ss_n_a === 1'b0) falls++;
         prev_ss = ss_n_a;
         if (data_valid_a === 1'b1) begin
            pulses++;
            compare_a("t4");
         end
      end
      check("t4_frames", 32'(falls), 32'd2);
      check("t4_results", 32'(pulses), 32'd2);
      data_ready_a = 1'b0;

      // Reset at the 8th sclk rise discards the partial frame
      tx_a_q.push_back(16'h5555);
      base = rises_a;
      pulse_start_a();
      cnt = 0;
      while ((rises_a - base) < 8 && cnt < 400) begin
         @(negedge clk);
         cnt++;
      end
      check("t5_reached_rise8", 32'(rises_a - base), 32'd8);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("t5_ss_n", 32'(ss_n_a), 32'd1);
      check("t5_sclk", 32'(sclk_a), 32'd1);
      check("t5_busy", 32'(busy_a), 32'd0);
      check("t5_valid", 32'(data_valid_a), 32'd0);
      seen_dv = 1'b0;
      repeat (80) begin
         @(negedge clk);
         if (data_valid_a !== 1'b0) seen_dv = 1'b1;
      end
      check("t5_no_partial_result", 32'(seen_dv), 32'd0);
      push_a(16'hC3A9);
      pulse_start_a();
      wait_ss_a(1'b1, "t5_clean_done");
      check("t5_clean_valid", 32'(data_valid_a), 32'd1);
      compare_a("t5");
      accept_a("t5");

      // Narrow instance: CLK_DIV=1, 12-bit frame, whole frame as data
      tx_b_q.push_back(12'hABC);
      exp_b_q.push_back(12'hABC);
      base = rises_b;
      start_b = 1'b1;
      @(negedge clk);
      start_b = 1'b0;
      cnt = 1;
      while (ss_n_b === 1'b0 && cnt < 400) begin
         @(negedge clk);
         if (ss_n_b === 1'b0) cnt++;
      end
      check("tb_ss_low_cycles", 32'(cnt), 32'd26);
      check("tb_sclk_rises", 32'(rises_b - base), 32'd12);
      check("tb_sclk_period", 32'(period_b), 32'd20);
      check("tb_valid", 32'(data_valid_b), 32'd1);
      check("tb_data_out", 32'(data_out_b), 32'(exp_b_q[0]));
      check("tb_frame_raw", 32'(frame_raw_b), 32'(exp_b_q.pop_front()));
      @(negedge clk);
      check("tb_auto_accept", 32'(data_valid_b), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
